// File: rtl/layer_skid_reg.sv
// Layer-boundary pipeline stage: registers one LUT-neuron layer's concatenated
// output vector behind a valid/ready handshake with a two-entry skid buffer.
// Ready and valid come straight from flops, so downstream stalls never reach
// the upstream layer combinationally, and one vector per cycle is sustained.
//
// Ports:
//   clk, rst        clock and synchronous active-high reset
//   s_valid/s_ready upstream handshake; s_data carries neuron Nk in bits [2k+1:2k]
//   m_valid/m_ready downstream handshake; m_data is the main register itself
//   occupancy       number of held vectors (0, 1 or 2)
module layer_skid_reg #(
  parameter int unsigned DATA_WIDTH = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [DATA_WIDTH-1:0] s_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic [1:0]            occupancy
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t                state;
  logic [DATA_WIDTH-1:0] skid;
  logic                  s_fire;
  logic                  m_fire;

  // Handshake events; both use only flopped ready/valid on the stage side.
  assign s_fire = s_valid & s_ready;
  assign m_fire = m_valid & m_ready;

  // The state encoding is the occupancy count.
  assign occupancy = 2'(state);

  // State, flopped handshake outputs, main (m_data) and skid registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= EMPTY;
      s_ready <= 1'b1;
      m_valid <= 1'b0;
      m_data  <= '0;
      skid    <= '0;
    end else begin
      case (state)
        EMPTY: begin
          if (s_fire) begin
            state   <= ONE;
            m_valid <= 1'b1;
            m_data  <= s_data;
          end
        end
        ONE: begin
          if (s_fire && m_fire) begin
            m_data <= s_data;
          end else if (s_fire) begin
            // Downstream stalled: park the new vector, main keeps the older one.
            state   <= FULL;
            s_ready <= 1'b0;
            skid    <= s_data;
          end else if (m_fire) begin
            state   <= EMPTY;
            m_valid <= 1'b0;
          end
        end
        FULL: begin
          if (m_fire) begin
            state   <= ONE;
            s_ready <= 1'b1;
            m_data  <= skid;
          end
        end
        default: begin
          state   <= EMPTY;
          s_ready <= 1'b1;
          m_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/layer_skid_reg.md
Name: layer_skid_reg

Overview:
- Layer-boundary pipeline stage that registers the concatenated 2-bit outputs of one LUT-neuron layer (e.g. layer1 N0..N31) before they fan out to the next layer's neuron inputs.
- Adds a valid/ready handshake and a two-entry skid buffer, so back-pressure from the downstream layer never combinationally reaches the upstream layer.
- Sustains one vector per cycle.

Parameters:
- DATA_WIDTH, 64, width of the concatenated layer output vector (neurons × output bits; 32 neurons × 2 bits by default).

Ports:
- clk  input  1  system clock; all state updates on its rising edge
- rst  input  1  synchronous, active-high reset
- s_valid  input  1  upstream layer vector valid
- s_ready  output  1  stage can accept a vector this cycle
- s_data  input  DATA_WIDTH  upstream layer vector (neuron N0 in bits [1:0], Nk in bits [2k+1:2k])
- m_valid  output  1  m_data holds a valid vector
- m_ready  input  1  downstream layer accepts m_data
- m_data  output  DATA_WIDTH  registered vector to the next layer's inputs
- occupancy  output  2  number of held vectors (0, 1 or 2)

Behaviour:
- Clock and reset: one clock, clk. rst is synchronous and active-high, sampled only on the rising edge of clk.
- Handshake events: s_fire = s_valid & s_ready; m_fire = m_valid & m_ready.
- Storage:
  - main register drives m_data directly.
  - skid register holds a second vector while the downstream is stalled.
- State machine, encoded in occupancy:
  - EMPTY (0): m_valid=0, s_ready=1.
  - ONE (1): m_valid=1, s_ready=1.
  - FULL (2): m_valid=1, s_ready=0.
- Transitions:
  - EMPTY & s_fire -> ONE; main <= s_data.
  - ONE & s_fire & m_fire -> ONE; main <= s_data.
  - ONE & s_fire & !m_fire -> FULL; skid <= s_data; main unchanged.
  - ONE & !s_fire & m_fire -> EMPTY.
  - FULL & m_fire -> ONE; main <= skid.
  - All other cases: hold state and data.
- s_ready and m_valid are pure functions of registered state. No combinational path exists from m_ready to s_ready, or from s_valid to m_valid.
- Latency: a vector accepted on cycle t appears on m_data with m_valid=1 at cycle t+1, provided the stage was EMPTY, or ONE with m_fire at t.
- Throughput: one vector per cycle while m_ready=1 continuously.
- Ordering is strictly FIFO; no vector is dropped or duplicated. m_data is stable while m_valid=1 and m_ready=0.
- s_data content is never inspected; arbitrary bit patterns pass through unchanged (all 2-bit codes 00..11 per neuron).
- Reset:
  - While rst=1: occupancy=0, m_valid=0, s_ready=1, main=0, skid=0.
  - Reset takes priority over any simultaneous s_fire or m_fire.
  - Reset mid-operation (ONE or FULL) discards held vectors; the next cycle behaves as EMPTY.
- Boundaries:
  - FULL with s_valid=1: not accepted (s_ready=0); upstream must hold s_data.
  - EMPTY with m_ready=1: no m_fire; m_data keeps its last value but m_valid=0.
  - FULL with simultaneous m_fire: accepts nothing that cycle (s_ready=0), goes to ONE.

Test Plan:
- Reset with occupancy=2 -> one cycle after rst deasserts: m_valid=0, s_ready=1, occupancy=0, m_data=0.
- m_ready held 1; drive 0x0000_0000_0000_0001, 0x5555_5555_5555_5555, 0xFFFF_FFFF_FFFF_FFFF on consecutive cycles -> same sequence on m_data one cycle later, m_valid=1 for three consecutive cycles, occupancy stays 1.
- m_ready=0; present A=0x1 then B=0x2 -> occupancy 1 then 2, s_ready=0 on the third cycle, m_data=0x1 held; raise m_ready -> m_data=0x1, then 0x2, then m_valid=0.
- In FULL, hold s_valid=1 with C=0x3 and pulse m_ready once -> occupancy 2->1, s_ready returns to 1; C accepted next cycle; output order A, B, C.
- Random s_valid/m_ready at 50% each over 10k vectors -> scoreboard sees in-order output, no loss or duplication; m_data stable during every stall; s_ready never depends on same-cycle m_ready.
- rst asserted in the same cycle as s_fire and m_fire from ONE -> occupancy=0, m_valid=0 next cycle; the accepted vector is not emitted.
